// File: rtl/eq_regs_pkg.sv
// Register map, bit positions and reset constants shared by the equalizer
// register slave and its sub-blocks.
package eq_regs_pkg;

  localparam int unsigned ADDR_CTRL      = 32'h00;
  localparam int unsigned ADDR_STATUS    = 32'h04;
  localparam int unsigned ADDR_TX_DATA   = 32'h08;
  localparam int unsigned ADDR_RX_DATA   = 32'h0C;
  localparam int unsigned ADDR_GAIN_BASE = 32'h10;
  localparam int unsigned ADDR_STICKY    = 32'h30;
  localparam int unsigned ADDR_IRQ_EN    = 32'h34;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_BYPASS = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int ST_TX_LEVEL_LSB = 0;
  localparam int ST_RX_LEVEL_LSB = 8;
  localparam int ST_TX_FULL      = 16;
  localparam int ST_RX_EMPTY     = 17;
  localparam int ST_STICKY_LSB   = 20;

  // Sticky bit order inside the 4-bit sticky field.
  localparam int STK_RX_NONEMPTY = 0;
  localparam int STK_TX_OVF      = 1;
  localparam int STK_RX_OVF      = 2;
  localparam int STK_RX_UNF      = 3;

  localparam logic [15:0] GAIN_RESET = 16'h4000;

  function automatic int unsigned word_index(input int unsigned byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/eq_sync_fifo.sv
// Single-clock show-ahead FIFO; push while full succeeds only alongside a pop,
// and flush clears both pointers ahead of any same-cycle push or pop.
module eq_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (o_level == '0);
  assign o_full    = (o_level == (AW+1)'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/eq_reg_bank.sv
// Simple-bus register slave for the equalizer: control, per-band gains, sticky
// status with irq, and the CPU<->core sample FIFOs.
module eq_reg_bank
  import eq_regs_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_BANDS          = 8,
  parameter int GAIN_W             = 16,
  parameter int SAMPLE_W           = 24,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     wrAddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     wrData,
  input  logic                              wr,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     rdAddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     rdData,
  input  logic                              rd,
  output logic [NUM_BANDS*GAIN_W-1:0]       gains,
  output logic                              eq_enable,
  output logic                              eq_bypass,
  output logic [SAMPLE_W-1:0]               in_sample,
  output logic                              in_valid,
  input  logic                              in_ready,
  input  logic [SAMPLE_W-1:0]               out_sample,
  input  logic                              out_valid,
  output logic                              out_ready,
  output logic                              irq
);
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int WW    = AW - 2;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAIN_WORD0 = int'(word_index(ADDR_GAIN_BASE));
  localparam logic [WW-1:0] W_CTRL   = WW'(word_index(ADDR_CTRL));
  localparam logic [WW-1:0] W_STATUS = WW'(word_index(ADDR_STATUS));
  localparam logic [WW-1:0] W_TX     = WW'(word_index(ADDR_TX_DATA));
  localparam logic [WW-1:0] W_RX     = WW'(word_index(ADDR_RX_DATA));
  localparam logic [WW-1:0] W_STICKY = WW'(word_index(ADDR_STICKY));
  localparam logic [WW-1:0] W_IRQ_EN = WW'(word_index(ADDR_IRQ_EN));

  logic                r_wr_q;
  logic [WW-1:0]       r_wr_word;
  logic [DW-1:0]       r_wr_data;
  logic [1:0]          r_ctrl;
  logic [3:0]          r_irq_en;
  logic [3:0]          r_sticky;
  logic [GAIN_W-1:0]   r_gain [NUM_BANDS];

  logic [WW-1:0]       w_rd_word;
  logic                w_commit;
  logic                w_flush;
  logic                w_tx_push_req;
  logic                w_rx_pop_req;
  logic                w_rx_push;
  logic [3:0]          w_sticky_set;
  logic [3:0]          w_sticky_clr;
  logic [DW-1:0]       w_status;
  logic [SAMPLE_W-1:0] w_tx_head;
  logic [SAMPLE_W-1:0] w_rx_head;
  logic                w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [LVL_W-1:0]    w_tx_level, w_rx_level;
  logic                w_unused_ok;

  // Sample streams: a beat transfers on any cycle where valid && ready are both high;
  // valid never depends on ready, and a source holds data stable until the transfer.
  // The bus write strobe may be held; the last captured pair commits once when wr drops.
  assign w_commit      = r_wr_q && !wr;
  assign w_flush       = w_commit && (r_wr_word == W_CTRL) && r_wr_data[CTRL_FLUSH];
  assign w_tx_push_req = w_commit && (r_wr_word == W_TX);
  assign w_rd_word     = rdAddr[AW-1:2];
  assign w_rx_pop_req  = rd && (w_rd_word == W_RX);
  assign w_rx_push     = out_valid && !w_rx_full;

  assign w_sticky_set[STK_RX_NONEMPTY] = w_rx_push && w_rx_empty && !w_flush;
  assign w_sticky_set[STK_TX_OVF]      = w_tx_push_req && w_tx_full && !in_ready;
  assign w_sticky_set[STK_RX_OVF]      = out_valid && w_rx_full;
  assign w_sticky_set[STK_RX_UNF]      = w_rx_pop_req && w_rx_empty;
  assign w_sticky_clr = (w_commit && (r_wr_word == W_STICKY)) ? r_wr_data[3:0] : 4'h0;

  eq_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_tx_fifo (
    .i_clk(S_AXI_ACLK), .i_rst(S_AXI_ARESET),
    .i_push(w_tx_push_req), .i_data(r_wr_data[SAMPLE_W-1:0]),
    .i_pop(in_ready), .i_flush(w_flush),
    .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(w_tx_level)
  );

  eq_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_rx_fifo (
    .i_clk(S_AXI_ACLK), .i_rst(S_AXI_ARESET),
    .i_push(w_rx_push), .i_data(out_sample),
    .i_pop(w_rx_pop_req), .i_flush(w_flush),
    .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(w_rx_level)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_wr_q    <= 1'b0;
      r_wr_word <= '0;
      r_wr_data <= '0;
      r_ctrl    <= 2'b00;
      r_irq_en  <= 4'h0;
      r_sticky  <= 4'h0;
      for (int k = 0; k < NUM_BANDS; k++) r_gain[k] <= GAIN_W'(GAIN_RESET);
    end else begin
      r_wr_q <= wr;
      if (wr) begin
        r_wr_word <= wrAddr[AW-1:2];
        r_wr_data <= wrData;
      end
      if (w_commit && (r_wr_word == W_CTRL))   r_ctrl   <= r_wr_data[CTRL_BYPASS:CTRL_ENABLE];
      if (w_commit && (r_wr_word == W_IRQ_EN)) r_irq_en <= r_wr_data[3:0];
      for (int k = 0; k < NUM_BANDS; k++) begin
        if (w_commit && (r_wr_word == WW'(GAIN_WORD0 + k))) r_gain[k] <= r_wr_data[GAIN_W-1:0];
      end
      r_sticky <= (r_sticky & ~w_sticky_clr) | w_sticky_set;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_TX_LEVEL_LSB +: LVL_W] = w_tx_level;
    w_status[ST_RX_LEVEL_LSB +: LVL_W] = w_rx_level;
    w_status[ST_TX_FULL]               = w_tx_full;
    w_status[ST_RX_EMPTY]              = w_rx_empty;
    w_status[ST_STICKY_LSB +: 4]       = r_sticky;
  end

  always_comb begin
    rdData = '0;
    case (w_rd_word)
      W_CTRL:   rdData[1:0] = r_ctrl;
      W_STATUS: rdData      = w_status;
      W_RX:     if (!w_rx_empty) rdData = {{(DW-SAMPLE_W){w_rx_head[SAMPLE_W-1]}}, w_rx_head};
      W_STICKY: rdData[3:0] = r_sticky;
      W_IRQ_EN: rdData[3:0] = r_irq_en;
      default:  ;
    endcase
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (w_rd_word == WW'(GAIN_WORD0 + k))
        rdData = {{(DW-GAIN_W){r_gain[k][GAIN_W-1]}}, r_gain[k]};
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_gains
    assign gains[k*GAIN_W +: GAIN_W] = r_gain[k];
  end

  assign eq_enable = r_ctrl[CTRL_ENABLE];
  assign eq_bypass = r_ctrl[CTRL_BYPASS];
  assign in_sample = w_tx_head;
  assign in_valid  = !w_tx_empty;
  assign out_ready = !w_rx_full;
  assign irq       = |(r_sticky & r_irq_en);

  assign w_unused_ok = &{1'b0, rdAddr[1:0], wrAddr[1:0], r_wr_data[DW-1:SAMPLE_W]};

endmodule
